prim_shreg_seq: RTL

PRIM_SHREG_SEQ -- requirements
Module: prim_shreg_seq

---
 rtl/prim_shreg_seq.sv | 108 ++++++++++
 1 files changed

// File: rtl/prim_shreg_seq.sv
// ----------------------------------------------------------------------------
// prim_shreg_seq : framed MSB-first serial shifter with programmable bit period
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module prim_shreg_seq #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             tx_valid_i,
  input  logic [WIDTH-1:0] tx_data_i,
  output logic             tx_ready_o,
  input  logic             abort_i,
  input  logic             serial_i,
  output logic             serial_o,
  output logic             bit_tick_o,
  output logic             busy_o,
  output logic             rx_valid_o,
  output logic [WIDTH-1:0] rx_data_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic [WIDTH-1:0] rx_data_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] bit_cnt;

  logic accept;
  logic tick;
  logic last_bit;
  logic [WIDTH-1:0] rx_next;

  // Abort outranks both a coincident accept and a coincident tick.
  assign accept   = (state == IDLE) && tx_valid_i && !abort_i;
  assign tick     = (state == SHIFT) && (div_cnt == div_q) && !abort_i;
  assign last_bit = tick && (bit_cnt == CNT_W'(1));
  assign rx_next  = {rx_sr[WIDTH-2:0], serial_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rx_data_q <= '0;
      div_q     <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            tx_sr   <= tx_data_i;
            div_q   <= div_i;
            div_cnt <= '0;
            rx_sr   <= '0;
            bit_cnt <= CNT_W'(WIDTH);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort_i) begin
            state <= IDLE;
          end else if (tick) begin
            div_cnt <= '0;
            rx_sr   <= rx_next;
            tx_sr   <= {tx_sr[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt - CNT_W'(1);
            if (last_bit) begin
              rx_data_q <= rx_next;
              state     <= DONE;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode the state directly so an async reset shows at once.
  assign tx_ready_o = (state == IDLE);
  assign busy_o     = (state != IDLE);
  assign serial_o   = (state == SHIFT) ? tx_sr[WIDTH-1] : 1'b0;
  assign bit_tick_o = tick;
  assign rx_valid_o = (state == DONE);
  assign rx_data_o  = rx_data_q;

endmodule

`default_nettype wire
